wb_arbiter: RTL and testbench

Writeback arbiter that owns the single write port of the 8×16 register file. It merges two result producers into one registered `reg_write`/`write_addr`/`write_data` stream:
- the ALU pipe, which always completes in order and has no backpressure;
- the load-return path, which may complete in the same cycle as the ALU and is buffered in a small queue.

It also exposes a forwarding lookup so decode can see values that are still pending writeback.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_load_queue.sv | 70 +++++++
 rtl/wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the load-queue entry type for the writeback arbiter.
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int QDEPTH = 4;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// Circular load-return FIFO with multi-entry pop and invalidate-by-address.
// Exposes every slot plus its age (0 = head) so the parent can search by order.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter  int DEPTH = QDEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [CNT_W-1:0]  i_pop_n,
    input  logic              i_kill_valid,
    input  logic [ADDR_W-1:0] i_kill_addr,
    output logic [CNT_W-1:0]  o_count,
    output wb_entry_t         o_entries [DEPTH],
    output logic [PTR_W-1:0]  o_age [DEPTH]
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_entries [DEPTH];

    logic [PTR_W-1:0] w_age [DEPTH];
    logic [DEPTH-1:0] w_popped;
    logic [DEPTH-1:0] w_killed;
    logic [DEPTH-1:0] w_pushed;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_age[gi]     = PTR_W'(gi) - r_head;
            assign w_popped[gi]  = ({1'b0, w_age[gi]} < i_pop_n);
            assign w_killed[gi]  = i_kill_valid && (r_entries[gi].addr == i_kill_addr);
            assign w_pushed[gi]  = i_push && (r_tail == PTR_W'(gi));
            assign o_entries[gi] = r_entries[gi];
            assign o_age[gi]     = w_age[gi];
        end
    endgenerate

    // Popped slots are cleared so that unoccupied slots are never live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_head  <= r_head + i_pop_n[PTR_W-1:0];
            r_tail  <= r_tail + PTR_W'(i_push);
            r_count <= r_count - i_pop_n + CNT_W'(i_push);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pushed[i]) begin
                    r_entries[i] <= {1'b1, i_push_addr, i_push_data};
                end else begin
                    r_entries[i].live <= r_entries[i].live && !w_popped[i] && !w_killed[i];
                end
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto one register-file port.
// DATA_W/ADDR_W must match wb_pkg, since the queue entry type is fixed there.
module wb_arbiter #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int QDEPTH = wb_pkg::QDEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] fwd_addr1,
    input  logic [ADDR_W-1:0] fwd_addr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic              ovf
);
    import wb_pkg::*;

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t         w_entries [QDEPTH];
    logic [PTR_W-1:0]  w_age [QDEPTH];
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_pop_n;
    logic              w_ld_ready;
    logic              w_ld_kill;
    logic              w_ld_accept;
    logic              w_push;
    logic              w_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;
    logic              w_live_any;
    logic [PTR_W-1:0]  w_oldest_age;
    logic [PTR_W-1:0]  w_oldest_idx;

    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_addr;
    logic [DATA_W-1:0] r_write_data;
    logic              r_ovf;

    wb_load_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk          (clk),
        .rst_n        (reset),
        .i_push       (w_push),
        .i_push_addr  (ld_addr),
        .i_push_data  (ld_data),
        .i_pop_n      (w_pop_n),
        .i_kill_valid (alu_valid),
        .i_kill_addr  (alu_addr),
        .o_count      (w_count),
        .o_entries    (w_entries),
        .o_age        (w_age)
    );

    assign w_ld_ready  = (w_count != CNT_W'(QDEPTH));
    assign w_ld_kill   = alu_valid && (ld_addr == alu_addr);
    assign w_ld_accept = ld_valid && w_ld_ready && !w_ld_kill;

    always_comb begin
        w_live_any   = 1'b0;
        w_oldest_age = '0;
        w_oldest_idx = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (w_entries[i].live && (!w_live_any || (w_age[i] < w_oldest_age))) begin
                w_live_any   = 1'b1;
                w_oldest_age = w_age[i];
                w_oldest_idx = PTR_W'(i);
            end
        end
    end

    // Dead entries ahead of the oldest live one are discarded in the same pop,
    // so they never cost a write slot.
    always_comb begin
        w_win      = 1'b0;
        w_win_addr = alu_addr;
        w_win_data = alu_data;
        w_pop_n    = '0;
        w_push     = 1'b0;
        if (alu_valid) begin
            w_win  = 1'b1;
            w_push = w_ld_accept;
        end else if (w_live_any) begin
            w_win      = 1'b1;
            w_win_addr = w_entries[w_oldest_idx].addr;
            w_win_data = w_entries[w_oldest_idx].data;
            w_pop_n    = {1'b0, w_oldest_age} + CNT_W'(1);
            w_push     = w_ld_accept;
        end else begin
            w_pop_n = w_count;
            if (w_ld_accept) begin
                w_win      = 1'b1;
                w_win_addr = ld_addr;
                w_win_data = ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_reg_write <= w_win;
            if (w_win) begin
                r_write_addr <= w_win_addr;
                r_write_data <= w_win_data;
            end
            if (ld_valid && !w_ld_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [ADDR_W-1:0] w_addr;
            logic              w_hit;
            logic [DATA_W-1:0] w_data;
            logic [PTR_W-1:0]  w_best_age;

            assign w_addr = (gi == 0) ? fwd_addr1 : fwd_addr2;

            // Youngest live queue entry first, then the value being written now.
            always_comb begin
                w_hit      = 1'b0;
                w_data     = '0;
                w_best_age = '0;
                for (int i = 0; i < QDEPTH; i++) begin
                    if (w_entries[i].live && (w_entries[i].addr == w_addr) &&
                        (!w_hit || (w_age[i] > w_best_age))) begin
                        w_hit      = 1'b1;
                        w_best_age = w_age[i];
                        w_data     = w_entries[i].data;
                    end
                end
                if (!w_hit && r_reg_write && (r_write_addr == w_addr)) begin
                    w_hit  = 1'b1;
                    w_data = r_write_data;
                end
            end
        end
    endgenerate

    assign fwd_hit1   = g_fwd[0].w_hit;
    assign fwd_data1  = g_fwd[0].w_data;
    assign fwd_hit2   = g_fwd[1].w_hit;
    assign fwd_data2  = g_fwd[1].w_data;
    assign ld_ready   = w_ld_ready;
    assign reg_write  = r_reg_write;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: bypass, queue drain, overflow, WAW kill,
// forwarding and asynchronous reset with queued loads.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        reg_write;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic [2:0]  fwd_addr1;
    logic [2:0]  fwd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] ld_regs [5] = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7};

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .fwd_addr1  (fwd_addr1),
        .fwd_addr2  (fwd_addr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-18s ok   got=%h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
    endtask

    initial begin
        reset     = 1'b0;
        fwd_addr1 = '0;
        fwd_addr2 = '0;
        clear_inputs();

        // reset state
        #12;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
        check("rst_fwd_data1", 32'(fwd_data1), 32'd0);
        reset = 1'b1;
        tick();

        // ALU write, one-cycle latency and one-cycle pulse
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h1234;
        tick();
        clear_inputs();
        fwd_addr1 = 3'd3;
        #1;
        check("alu_reg_write", 32'(reg_write), 32'd1);
        check("alu_write_addr", 32'(write_addr), 32'd3);
        check("alu_write_data", 32'(write_data), 32'h1234);
        check("alu_fwd_hit", 32'(fwd_hit1), 32'd1);
        check("alu_fwd_data", 32'(fwd_data1), 32'h1234);
        tick();
        check("alu_pulse_end", 32'(reg_write), 32'd0);
        check("alu_addr_hold", 32'(write_addr), 32'd3);
        check("alu_fwd_gone", 32'(fwd_hit1), 32'd0);

        // load bypass through an idle queue
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'hBEEF;
        #1;
        check("byp_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        clear_inputs();
        check("byp_reg_write", 32'(reg_write), 32'd1);
        check("byp_write_addr", 32'(write_addr), 32'd5);
        check("byp_write_data", 32'(write_data), 32'hBEEF);
        check("byp_count", 32'(dut.w_count), 32'd0);
        tick();

        // ALU busy for 6 cycles: fill queue, overflow, then drain in order
        for (int k = 0; k < 6; k++) begin
            alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 16'h0100 + 16'(k);
            if (k < 5) begin
                ld_valid = 1'b1; ld_addr = ld_regs[k]; ld_data = 16'hD000 + 16'(k);
            end else begin
                ld_valid = 1'b0;
            end
            #1;
            check($sformatf("fill_ready_%0d", k), 32'(ld_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("fill_alu_data_%0d", k), 32'(write_data), 32'h0100 + 32'(k));
        end
        check("fill_ovf", 32'(ovf), 32'd1);
        clear_inputs();
        fwd_addr1 = 3'd4;
        fwd_addr2 = 3'd7;
        #1;
        check("fill_fwd_hit_r4", 32'(fwd_hit1), 32'd1);
        check("fill_fwd_data_r4", 32'(fwd_data1), 32'hD002);
        check("fill_fwd_miss_r7", 32'(fwd_hit2), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("drain_we_%0d", j), 32'(reg_write), 32'd1);
            check($sformatf("drain_addr_%0d", j), 32'(write_addr), 32'(ld_regs[j]));
            check($sformatf("drain_data_%0d", j), 32'(write_data), 32'hD000 + 32'(j));
        end
        tick();
        check("drain_done_we", 32'(reg_write), 32'd0);
        check("drain_done_ready", 32'(ld_ready), 32'd1);

        // WAW kill of a queued load, dead head skipped in favour of a bypass
        alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 16'h0300;
        ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 16'h0011;
        tick();
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h0022;
        ld_valid = 1'b0;
        fwd_addr1 = 3'd2;
        #1;
        check("kill_fwd_queued", 32'(fwd_data1), 32'h0011);
        tick();
        clear_inputs();
        check("kill_we", 32'(reg_write), 32'd1);
        check("kill_addr", 32'(write_addr), 32'd2);
        check("kill_data", 32'(write_data), 32'h0022);
        check("kill_fwd_hit", 32'(fwd_hit1), 32'd1);
        check("kill_fwd_data", 32'(fwd_data1), 32'h0022);
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'h7777;
        tick();
        clear_inputs();
        check("dead_byp_we", 32'(reg_write), 32'd1);
        check("dead_byp_addr", 32'(write_addr), 32'd5);
        check("dead_byp_data", 32'(write_data), 32'h7777);
        check("dead_byp_count", 32'(dut.w_count), 32'd0);
        check("dead_fwd_miss_hit", 32'(fwd_hit1), 32'd0);
        check("dead_fwd_miss_data", 32'(fwd_data1), 32'd0);
        tick();
        check("dead_no_write", 32'(reg_write), 32'd0);

        // same-cycle ALU and load to the same register
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 16'hAAAA;
        ld_valid = 1'b1; ld_addr = 3'd4; ld_data = 16'h5555;
        tick();
        clear_inputs();
        check("same_addr", 32'(write_addr), 32'd4);
        check("same_data", 32'(write_data), 32'hAAAA);
        check("same_count", 32'(dut.w_count), 32'd0);
        tick();
        check("same_no_second", 32'(reg_write), 32'd0);

        // async reset with three queued loads
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 16'h0500 + 16'(k);
            ld_valid = 1'b1; ld_addr = 3'(k + 1); ld_data = 16'hE000 + 16'(k);
            tick();
        end
        check("pre_rst_count", 32'(dut.w_count), 32'd3);
        check("pre_rst_we", 32'(reg_write), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_we", 32'(reg_write), 32'd0);
        check("arst_data", 32'(write_data), 32'd0);
        check("arst_ready", 32'(ld_ready), 32'd1);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_count", 32'(dut.w_count), 32'd0);
        clear_inputs();
        tick();
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("post_rst_we_%0d", j), 32'(reg_write), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
